// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves B-type / JAL / JALR control transfers. It drives the
//               comparator's unsigned-mode select, samples the less/equal
//               flags on the accept edge, computes and registers the target,
//               and holds a redirect request to fetch under a valid/ready
//               handshake until fetch accepts it.
//               Optional statistics counters are enabled by defining the
//               macro BRU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_br_valid,
    output logic            o_br_ready,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_data,
    output logic            o_br_un,
    input  logic            i_br_less,
    input  logic            i_br_equal,
    output logic            o_redirect_valid,
    input  logic            i_redirect_ready,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_resolved,
    output logic            o_illegal,
    output logic            o_misalign,
    output logic [31:0]     o_stat_total,
    output logic [31:0]     o_stat_taken
);

    // B-type condition codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic            accept;
    logic            redirect_accept;
    logic            sel_jalr;
    logic            sel_jal;
    logic            sel_branch;
    logic            cond_taken;
    logic            cond_illegal;
    logic            raw_taken;
    logic            target_misaligned;
    logic            redirect_go;
    logic [XLEN-1:0] pc_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_q;
    logic            resolved_q;
    logic            illegal_q;
    logic            misalign_q;

    // Handshakes: ready only while no redirect is pending
    assign o_br_ready      = (state == S_IDLE);
    assign accept          = i_br_valid & o_br_ready;
    assign redirect_accept = (state == S_REDIRECT) & i_redirect_ready;

    // Unsigned compare for BLTU/BGEU
    assign o_br_un = (i_funct3[2:1] == 2'b11);

    // JALR wins when both jump flags are set
    assign sel_jalr   = i_is_jalr;
    assign sel_jal    = i_is_jal & ~i_is_jalr;
    assign sel_branch = ~i_is_jal & ~i_is_jalr;

    // Target arithmetic wraps modulo 2^XLEN
    assign pc_sum   = i_pc + i_imm;
    assign jalr_sum = i_rs1_data + i_imm;
    assign target   = sel_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_sum;

    // B-type condition decode from the comparator flags
    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:           cond_taken = i_br_equal;
            F3_BNE:           cond_taken = ~i_br_equal;
            F3_BLT, F3_BLTU:  cond_taken = i_br_less;
            F3_BGE, F3_BGEU:  cond_taken = ~i_br_less;
            F3_RSV2, F3_RSV3: cond_illegal = 1'b1;
            default:          cond_illegal = 1'b1;
        endcase
    end

    // Jumps are unconditional; a misaligned taken target is dropped
    assign raw_taken         = sel_branch ? cond_taken : 1'b1;
    assign target_misaligned = raw_taken &
                               (target[1] | (~sel_jalr & target[0]));
    assign redirect_go       = raw_taken & ~target_misaligned;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && redirect_go) begin
                    state_next = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (i_redirect_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign o_redirect_valid = (state == S_REDIRECT);

    // Target register: captured on every accept, held while redirect pends
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_pc <= RESET_PC;
        end else if (accept) begin
            redirect_pc <= target;
        end
    end

    assign o_redirect_pc = redirect_pc;

    // One-cycle status pulses following accept / redirect acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_q    <= 1'b0;
            resolved_q <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            flush_q    <= redirect_accept;
            resolved_q <= accept;
            illegal_q  <= accept & sel_branch & cond_illegal;
            misalign_q <= accept & target_misaligned;
        end
    end

    assign o_flush    = flush_q;
    assign o_resolved = resolved_q;
    assign o_illegal  = illegal_q;
    assign o_misalign = misalign_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_total;
    logic [31:0] stat_taken;

    // Saturating counters of resolved and redirected branches
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_total <= 32'h0;
            stat_taken <= 32'h0;
        end else begin
            if (accept && (stat_total != 32'hFFFF_FFFF)) begin
                stat_total <= stat_total + 32'd1;
            end
            if (redirect_accept && (stat_taken != 32'hFFFF_FFFF)) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end

    assign o_stat_total = stat_total;
    assign o_stat_taken = stat_taken;
`else
    assign o_stat_total = 32'h0;
    assign o_stat_taken = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit. A transaction-
//               level model predicts every output each cycle; directed
//               scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] pc = 32'h0;
    logic [31:0] imm = 32'h0;
    logic [31:0] rs1 = 32'h0;
    logic        br_less = 1'b0;
    logic        br_equal = 1'b0;
    logic        redirect_ready = 1'b1;

    logic        o_br_ready;
    logic        o_br_un;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_flush;
    logic        o_resolved;
    logic        o_illegal;
    logic        o_misalign;
    logic [31:0] o_stat_total;
    logic [31:0] o_stat_taken;

    int n_cmp = 0;
    int n_err = 0;

    branch_resolve_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_br_valid       (br_valid),
        .o_br_ready       (o_br_ready),
        .i_is_jal         (is_jal),
        .i_is_jalr        (is_jalr),
        .i_funct3         (funct3),
        .i_pc             (pc),
        .i_imm            (imm),
        .i_rs1_data       (rs1),
        .o_br_un          (o_br_un),
        .i_br_less        (br_less),
        .i_br_equal       (br_equal),
        .o_redirect_valid (o_redirect_valid),
        .i_redirect_ready (redirect_ready),
        .o_redirect_pc    (o_redirect_pc),
        .o_flush          (o_flush),
        .o_resolved       (o_resolved),
        .o_illegal        (o_illegal),
        .o_misalign       (o_misalign),
        .o_stat_total     (o_stat_total),
        .o_stat_taken     (o_stat_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_pend = 0;
    logic [31:0] m_pc = RESET_PC;
    bit          m_flush = 0, m_res = 0, m_ill = 0, m_mis = 0;
    longint      m_tot = 0, m_tkn = 0;

    function automatic void resolve(input bit jal, input bit jalr, input logic [2:0] f3,
                                    input logic [31:0] p, input logic [31:0] im,
                                    input logic [31:0] r1, input bit eq, input bit lt,
                                    output bit tk, output logic [31:0] tgt,
                                    output bit ill, output bit mis);
        ill = 0;
        tk  = 0;
        if (jalr) begin
            tgt = (r1 + im) & 32'hFFFF_FFFE;
            tk  = 1;
        end else begin
            tgt = p + im;
            if (jal) tk = 1;
            else begin
                case (f3)
                    3'd0:       tk = eq;
                    3'd1:       tk = !eq;
                    3'd4, 3'd6: tk = lt;
                    3'd5, 3'd7: tk = !lt;
                    default:    ill = 1;
                endcase
            end
        end
        mis = tk && ((tgt % 4) != 0);
        if (mis) tk = 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_pc = RESET_PC;
            m_flush = 0; m_res = 0; m_ill = 0; m_mis = 0;
            m_tot = 0; m_tkn = 0;
        end else begin
            bit acc, tk, ill, mis;
            logic [31:0] tgt;
            acc     = br_valid && !m_pend;
            m_flush = m_pend && redirect_ready;
            if (m_flush) begin
                m_pend = 0;
                if (m_tkn < 64'hFFFF_FFFF) m_tkn++;
            end
            m_res = acc; m_ill = 0; m_mis = 0;
            if (acc) begin
                resolve(is_jal, is_jalr, funct3, pc, imm, rs1, br_equal, br_less,
                        tk, tgt, ill, mis);
                m_pc  = tgt;
                m_ill = ill;
                m_mis = mis;
                m_pend = tk;
                if (m_tot < 64'hFFFF_FFFF) m_tot++;
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        chk("br_ready",       {31'b0, o_br_ready},       {31'b0, !m_pend});
        chk("redirect_valid", {31'b0, o_redirect_valid}, {31'b0, m_pend});
        if (m_pend) chk("redirect_pc", o_redirect_pc, m_pc);
        chk("flush",    {31'b0, o_flush},    {31'b0, m_flush});
        chk("resolved", {31'b0, o_resolved}, {31'b0, m_res});
        chk("illegal",  {31'b0, o_illegal},  {31'b0, m_ill});
        chk("misalign", {31'b0, o_misalign}, {31'b0, m_mis});
        chk("br_un",    {31'b0, o_br_un},    {31'b0, (funct3 >= 3'd6)});
`ifdef BRU_STATS_EN
        chk("stat_total", o_stat_total, m_tot[31:0]);
        chk("stat_taken", o_stat_taken, m_tkn[31:0]);
`else
        chk("stat_total", o_stat_total, 32'h0);
        chk("stat_taken", o_stat_taken, 32'h0);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit jal, input bit jalr, input logic [2:0] f3,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                         input bit eq, input bit lt);
        br_valid = 1; is_jal = jal; is_jalr = jalr; funct3 = f3;
        pc = p; imm = im; rs1 = r1; br_equal = eq; br_less = lt;
    endtask

    initial begin
        // Reset
        #2;
        chk("rst_ready",  {31'b0, o_br_ready},       32'd1);
        chk("rst_valid",  {31'b0, o_redirect_valid}, 32'd0);
        chk("rst_pc",     o_redirect_pc,             RESET_PC);
        repeat (2) step();
        rst_n = 1;
        step();

        // BEQ taken: pc 0x100 + 0x20
        drive(0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0);
        step(); br_valid = 0;
        chk("beq_valid", {31'b0, o_redirect_valid}, 32'd1);
        chk("beq_pc",    o_redirect_pc,             32'h120);
        step();
        chk("beq_flush", {31'b0, o_flush},          32'd1);
        chk("beq_idle",  {31'b0, o_redirect_valid}, 32'd0);
        step();

        // BLTU not taken, then back-to-back BNE taken
        drive(0, 0, 3'b110, 32'h300, 32'h10, 32'h0, 0, 0);
        #1 chk("bltu_un", {31'b0, o_br_un}, 32'd1);
        step();
        chk("bltu_valid",    {31'b0, o_redirect_valid}, 32'd0);
        chk("bltu_resolved", {31'b0, o_resolved},       32'd1);
        chk("bltu_ready",    {31'b0, o_br_ready},       32'd1);
        drive(0, 0, 3'b001, 32'h400, 32'hFFFF_FFF0, 32'h0, 0, 0);
        step(); br_valid = 0;
        chk("bne_valid", {31'b0, o_redirect_valid}, 32'd1);
        chk("bne_pc",    o_redirect_pc,             32'h3F0);
        step(); step();

        // JALR: 0x1003+4 -> 0x1006 misaligned; 0x1001+0 -> 0x1000 redirect
        drive(0, 1, 3'b000, 32'h0, 32'h4, 32'h1003, 0, 0);
        step(); br_valid = 0;
        chk("jalr_mis",   {31'b0, o_misalign},       32'd1);
        chk("jalr_mis_v", {31'b0, o_redirect_valid}, 32'd0);
        drive(1, 1, 3'b000, 32'h0, 32'h0, 32'h1001, 0, 0);
        step(); br_valid = 0;
        chk("jalr_valid", {31'b0, o_redirect_valid}, 32'd1);
        chk("jalr_pc",    o_redirect_pc,             32'h1000);
        step(); step();

        // BGE taken with fetch backpressure for 5 cycles
        redirect_ready = 0;
        drive(0, 0, 3'b101, 32'h200, 32'h40, 32'h0, 0, 0);
        step();
        drive(0, 0, 3'b000, 32'h800, 32'h8, 32'h0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, o_redirect_valid}, 32'd1);
            chk("hold_pc",    o_redirect_pc,             32'h240);
            chk("hold_ready", {31'b0, o_br_ready},       32'd0);
            step();
        end
        br_valid = 0; redirect_ready = 1;
        step();
        chk("bge_flush", {31'b0, o_flush}, 32'd1);
        step();
        chk("bge_flush_once", {31'b0, o_flush}, 32'd0);

        // Reserved funct3 and misaligned JAL
        drive(0, 0, 3'b010, 32'h100, 32'h20, 32'h0, 1, 1);
        step(); br_valid = 0;
        chk("illegal",   {31'b0, o_illegal},        32'd1);
        chk("illegal_v", {31'b0, o_redirect_valid}, 32'd0);
        drive(1, 0, 3'b000, 32'h100, 32'h6, 32'h0, 0, 0);
        step(); br_valid = 0;
        chk("jal_mis",   {31'b0, o_misalign},       32'd1);
        chk("jal_mis_v", {31'b0, o_redirect_valid}, 32'd0);
        step();

        // Reset while a redirect is pending
        redirect_ready = 0;
        drive(0, 0, 3'b000, 32'h500, 32'h4, 32'h0, 1, 0);
        step(); br_valid = 0;
        chk("pre_rst_valid", {31'b0, o_redirect_valid}, 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", {31'b0, o_redirect_valid}, 32'd0);
        chk("mid_rst_pc",    o_redirect_pc,             RESET_PC);
        chk("mid_rst_ready", {31'b0, o_br_ready},       32'd1);
        redirect_ready = 1;
        step();
        rst_n = 1;
        step();
        chk("post_rst_flush", {31'b0, o_flush}, 32'd0);

        // Three branches, two taken, for statistics
        drive(0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0);
        step(); br_valid = 0; step();
        drive(0, 0, 3'b001, 32'h100, 32'h20, 32'h0, 1, 0);
        step(); br_valid = 0;
        drive(1, 0, 3'b000, 32'h100, 32'h80, 32'h0, 0, 0);
        step(); br_valid = 0; step(); step();
`ifdef BRU_STATS_EN
        chk("stat_total_lit", o_stat_total, 32'd3);
        chk("stat_taken_lit", o_stat_taken, 32'd2);
`else
        chk("stat_total_lit", o_stat_total, 32'd0);
        chk("stat_taken_lit", o_stat_taken, 32'd0);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
